// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    // Source 0 carries irq_timer from Timer_NormalMode and has top priority.
    localparam int TIMER_SRC_IDX = 0;

    // Width of the optional request timestamp.
    localparam int TS_W = 32;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the masked pending vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] masked,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                idx   = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge detect, pending latch, enable mask, priority
// select and a REQ/ack, SERVICE/eoi handshake towards the CPU.
// Source 0 is irq_timer.
// Define IRQ_TIMESTAMP_EN to add the irq_ts port, which captures timer_cnt
// when each request is issued.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no request outstanding; issue one when any masked bit pends
//   REQ     | cpu_irq high, irq_id committed; waiting for cpu_ack
//   SERVICE | request accepted; irq_id held; waiting for cpu_eoi
module irq_ctrl
    import irq_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] irq_en,
    input  logic [31:0]      timer_cnt,
    input  logic             cpu_ack,
    input  logic             cpu_eoi,
    output logic             cpu_irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending
`ifdef IRQ_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  irq_ts
`endif
);

    logic [N_SRC-1:0] src_q, src_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] masked;
    logic [ID_W-1:0]  enc_idx;
    logic             enc_valid;

    irq_state_e       state_q, state_d;
    logic             cpu_irq_q, cpu_irq_d;
    logic [ID_W-1:0]  irq_id_q, irq_id_d;

`ifdef IRQ_TIMESTAMP_EN
    logic [TS_W-1:0]  irq_ts_q, irq_ts_d;
`else
    // timer_cnt stays on the interface so both builds share one port list.
    logic             unused_timer_cnt;
    assign unused_timer_cnt = ^timer_cnt;
`endif

    assign masked = pending_q & irq_en;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .masked (masked),
        .idx    (enc_idx),
        .valid  (enc_valid)
    );

    // Edge detect and pending update; a new rise overrides an ack clear on the same bit.
    always_comb begin
        src_d     = irq_src;
        rise      = irq_src & ~src_q;
        pending_d = pending_q;
        if (state_q == REQ && cpu_ack) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (irq_id_q == ID_W'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        pending_d = pending_d | rise;
    end

    // Next-state and registered-output logic for the CPU handshake.
    always_comb begin
        state_d   = state_q;
        cpu_irq_d = cpu_irq_q;
        irq_id_d  = irq_id_q;
`ifdef IRQ_TIMESTAMP_EN
        irq_ts_d  = irq_ts_q;
`endif
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d   = REQ;
                    cpu_irq_d = 1'b1;
                    irq_id_d  = enc_idx;
`ifdef IRQ_TIMESTAMP_EN
                    irq_ts_d  = timer_cnt;
`endif
                end
            end
            REQ: begin
                // ack wins over a simultaneous eoi; eoi only counts in SERVICE
                if (cpu_ack) begin
                    state_d   = SERVICE;
                    cpu_irq_d = 1'b0;
                end
            end
            SERVICE: begin
                if (cpu_eoi) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cpu_irq_d = 1'b0;
            end
        endcase
    end

    // Edge-detect history and pending register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= src_d;
            pending_q <= pending_d;
        end
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cpu_irq_q <= 1'b0;
            irq_id_q  <= '0;
`ifdef IRQ_TIMESTAMP_EN
            irq_ts_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cpu_irq_q <= cpu_irq_d;
            irq_id_q  <= irq_id_d;
`ifdef IRQ_TIMESTAMP_EN
            irq_ts_q  <= irq_ts_d;
`endif
        end
    end

    assign cpu_irq = cpu_irq_q;
    assign irq_id  = irq_id_q;
    assign pending = pending_q;
`ifdef IRQ_TIMESTAMP_EN
    assign irq_ts  = irq_ts_q;
`endif

endmodule
